// File: rtl/moore_tff_counter_n.sv
// ---------------------------------------------------------------------------
// moore_tff_counter_n
//
// Parametrised Moore counter whose state register is made only of toggle
// flip-flops. Each bit flips when its T input is 1, and every T input is a
// combinational function of the present state and the inputs. The design
// generalises the 2-bit "count on x_in, flag on 11" Moore machine with
// up/down counting, synchronous parallel load, a programmable match state
// and a registered wrap pulse.
//
// Parameters:
//   WIDTH     number of state bits / toggle flip-flops (1..16)
//   MATCH     state value at which y_out is asserted
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset, clears state and wrap
//   x_in      count enable, one step per clock edge while high
//   dir       count direction, 0 = up, 1 = down
//   load      synchronous load strobe, overrides x_in and dir
//   load_val  value loaded into the state when load is high
//   state     present state (flip-flop Q outputs)
//   y_out     Moore output, high iff state == MATCH
//   wrap      registered one-cycle pulse after a boundary step
//
// Optional feature macro: MOORE_TFF_SATURATE_EN
//   When defined, a step attempted at the boundary (up at all-ones, down at
//   zero) holds the state instead of wrapping, and wrap pulses once for every
//   such attempt as an overflow/underflow flag. When undefined the counter
//   wraps modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module moore_tff_counter_n #(
    parameter int               WIDTH = 2,
    parameter logic [WIDTH-1:0] MATCH = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             y_out,
    output logic             wrap
);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] down_t;
    logic             at_max;
    logic             at_min;
    logic             boundary;
    logic             wrap_next;

    // Toggle chains for counting. A bit toggles on an up-count when all
    // lower bits are one (running AND), and on a down-count when all lower
    // bits are zero (running NOR). Bit 0 always toggles on a step.
    always_comb begin
        up_t      = '0;
        down_t    = '0;
        up_t[0]   = 1'b1;
        down_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i]   = up_t[i-1] & state[i-1];
            down_t[i] = down_t[i-1] & ~state[i-1];
        end
    end

    assign at_max   = &state;
    assign at_min   = ~|state;
    assign boundary = dir ? at_min : at_max;

    // T equations in priority order: load, hold, count. A load is expressed
    // as a toggle of exactly the bits that differ from load_val, so the
    // register stays a pure T-flop bank.
    always_comb begin
        t         = '0;
        wrap_next = 1'b0;
        if (load) begin
            t = state ^ load_val;
        end else if (x_in) begin
            t         = dir ? down_t : up_t;
            wrap_next = boundary;
`ifdef MOORE_TFF_SATURATE_EN
            if (boundary) begin
                t = '0;
            end
`endif
        end
    end

    // T flip-flop bank plus the registered wrap pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state ^ t;
            wrap  <= wrap_next;
        end
    end

    // Moore output depends on the state only.
    assign y_out = (state == MATCH);

endmodule
